// File: rtl/traffic_ctrl_param_if.sv
// Request/lamp bundle between the intersection controller (master) and its environment (slave).
// Lamps and phase are registered in the controller; requests have no backpressure.
interface traffic_ctrl_param_if;
    logic       left_req_ns;
    logic       left_req_ew;
    logic       emerg;
    logic       ns_left_green;
    logic       ns_green;
    logic       ns_yellow;
    logic       ns_red;
    logic       ew_left_green;
    logic       ew_green;
    logic       ew_yellow;
    logic       ew_red;
    logic [2:0] phase;

    modport master (
        input  left_req_ns, left_req_ew, emerg,
        output ns_left_green, ns_green, ns_yellow, ns_red,
        output ew_left_green, ew_green, ew_yellow, ew_red,
        output phase
    );

    modport slave (
        output left_req_ns, left_req_ew, emerg,
        input  ns_left_green, ns_green, ns_yellow, ns_red,
        input  ew_left_green, ew_green, ew_yellow, ew_red,
        input  phase
    );
endinterface

// File: rtl/traffic_ctrl_param.sv
// Demand-actuated NS/EW intersection controller with optional protected lefts and emergency preempt.
// Lamps and phase update on the same edge as the state; requests are latched, nothing is backpressured.
module traffic_ctrl_param #(
    parameter int CNT_W    = 8,
    parameter int T_GREEN  = 20,
    parameter int T_LEFT   = 8,
    parameter int T_YELLOW = 3,
    parameter int T_ALLRED = 2,
    parameter bit LEFT_EN  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    traffic_ctrl_param_if.master bus
);

    typedef enum logic [2:0] {
        NS_LEFT  = 3'd0,
        NS_GREEN = 3'd1,
        NS_YEL   = 3'd2,
        AR_NS    = 3'd3,
        EW_LEFT  = 3'd4,
        EW_GREEN = 3'd5,
        EW_YEL   = 3'd6,
        AR_EW    = 3'd7
    } state_t;

    typedef struct packed {
        logic left_green;
        logic green;
        logic yellow;
        logic red;
    } road_lamp_t;

    localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(T_GREEN  - 1);
    localparam logic [CNT_W-1:0] LD_LEFT   = CNT_W'(T_LEFT   - 1);
    localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] LD_ALLRED = CNT_W'(T_ALLRED - 1);
    localparam road_lamp_t       LAMP_RED  = '{left_green: 1'b0, green: 1'b0, yellow: 1'b0, red: 1'b1};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             pend_ns_q, pend_ns_d;
    logic             pend_ew_q, pend_ew_d;
    road_lamp_t       ns_lamp_q, ns_lamp_d;
    road_lamp_t       ew_lamp_q, ew_lamp_d;
    logic             tmo;

    assign tmo = (timer_q == '0);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q - CNT_W'(1);

        unique case (state_q)
            NS_LEFT: begin
                if (bus.emerg) begin
                    state_d = NS_YEL;
                    timer_d = LD_YELLOW;
                end else if (tmo) begin
                    state_d = NS_GREEN;
                    timer_d = LD_GREEN;
                end
            end
            NS_GREEN: begin
                if (bus.emerg || tmo) begin
                    state_d = NS_YEL;
                    timer_d = LD_YELLOW;
                end
            end
            NS_YEL: begin
                if (tmo) begin
                    state_d = AR_NS;
                    timer_d = LD_ALLRED;
                end
            end
            AR_NS: begin
                // Preempt parks here with a fresh clearance pending.
                if (bus.emerg) begin
                    timer_d = LD_ALLRED;
                end else if (tmo) begin
                    if (LEFT_EN && pend_ew_q) begin
                        state_d = EW_LEFT;
                        timer_d = LD_LEFT;
                    end else begin
                        state_d = EW_GREEN;
                        timer_d = LD_GREEN;
                    end
                end
            end
            EW_LEFT: begin
                if (bus.emerg) begin
                    state_d = EW_YEL;
                    timer_d = LD_YELLOW;
                end else if (tmo) begin
                    state_d = EW_GREEN;
                    timer_d = LD_GREEN;
                end
            end
            EW_GREEN: begin
                if (bus.emerg || tmo) begin
                    state_d = EW_YEL;
                    timer_d = LD_YELLOW;
                end
            end
            EW_YEL: begin
                if (tmo) begin
                    state_d = AR_EW;
                    timer_d = LD_ALLRED;
                end
            end
            AR_EW: begin
                if (bus.emerg) begin
                    timer_d = LD_ALLRED;
                end else if (tmo) begin
                    if (LEFT_EN && pend_ns_q) begin
                        state_d = NS_LEFT;
                        timer_d = LD_LEFT;
                    end else begin
                        state_d = NS_GREEN;
                        timer_d = LD_GREEN;
                    end
                end
            end
            default: begin
                state_d = AR_EW;
                timer_d = LD_ALLRED;
            end
        endcase

        // Clear on entry to the left phase takes priority over a same-edge request.
        pend_ns_d = 1'b0;
        pend_ew_d = 1'b0;
        if (LEFT_EN) begin
            pend_ns_d = pend_ns_q | (bus.left_req_ns && (state_q != NS_LEFT));
            pend_ew_d = pend_ew_q | (bus.left_req_ew && (state_q != EW_LEFT));
            if ((state_d == NS_LEFT) && (state_q != NS_LEFT)) begin
                pend_ns_d = 1'b0;
            end
            if ((state_d == EW_LEFT) && (state_q != EW_LEFT)) begin
                pend_ew_d = 1'b0;
            end
        end

        ns_lamp_d = '{
            left_green: (state_d == NS_LEFT),
            green:      (state_d == NS_GREEN),
            yellow:     (state_d == NS_YEL),
            red:        !((state_d == NS_GREEN) || (state_d == NS_YEL))
        };
        ew_lamp_d = '{
            left_green: (state_d == EW_LEFT),
            green:      (state_d == EW_GREEN),
            yellow:     (state_d == EW_YEL),
            red:        !((state_d == EW_GREEN) || (state_d == EW_YEL))
        };
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= AR_EW;
            timer_q   <= LD_ALLRED;
            pend_ns_q <= 1'b0;
            pend_ew_q <= 1'b0;
            ns_lamp_q <= LAMP_RED;
            ew_lamp_q <= LAMP_RED;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            pend_ns_q <= pend_ns_d;
            pend_ew_q <= pend_ew_d;
            ns_lamp_q <= ns_lamp_d;
            ew_lamp_q <= ew_lamp_d;
        end
    end

    assign bus.ns_left_green = ns_lamp_q.left_green;
    assign bus.ns_green      = ns_lamp_q.green;
    assign bus.ns_yellow     = ns_lamp_q.yellow;
    assign bus.ns_red        = ns_lamp_q.red;
    assign bus.ew_left_green = ew_lamp_q.left_green;
    assign bus.ew_green      = ew_lamp_q.green;
    assign bus.ew_yellow     = ew_lamp_q.yellow;
    assign bus.ew_red        = ew_lamp_q.red;
    assign bus.phase         = state_q;

endmodule
